vdp_super_res_writer: RTL
=========================

// Module: vdp_super_res_writer
// PURPOSE
// - Write-side counterpart of the super-res/super-mid pixel fetch path.
// - Accepts 8-bit palette-index bytes from the CPU port and packs them into 32-bit VRAM words with byte enables.
// - Queues the packed words and issues them to VRAM only while the fetch path has released the bus (super_res_drawing=0).
// - Byte address 0 is pixel 0 of a page. Word address = byte address [19:2]. Lane n = bits [8n+7:8n].
// PARAMETERS
// FIFO_DEPTH     4   packed-word queue entries; power of 2, minimum 2
// FLUSH_TIMEOUT  64  idle cycles before a partial word auto-flushes (used only with the macro)
// PORTS
// clk                input   1   system clock
// reset_n            input   1   asynchronous reset, active-low
// vdp_super          input   1   super modes enabled; 0 = writer frozen
// super_res_drawing  input   1   1 = fetch path owns the VRAM bus
// wr_addr_load       input   1   load byte pointer from wr_addr_in
// wr_addr_in         input  20   byte address
// wr_data_valid      input   1   a byte is offered on wr_data
// wr_data            input   8   palette index
// wr_ready           output  1   byte accepted when wr_data_valid && wr_ready
// flush              input   1   1-cycle pulse: push the partial word
// vram_req           output  1   write request
// vram_addr          output 18   VRAM word address
// vram_wdata         output 32   write data
// vram_be            output  4   byte enables
// vram_ack           input   1   1-cycle acknowledge; head entry is consumed
// idle               output  1   pack empty, FIFO empty, no request outstanding
// BEHAVIOUR
// - Reset (async, reset_n=0): ptr=0, pack empty, FIFO empty, vram_req=0, vram_addr=0, vram_wdata=0, vram_be=0, wr_ready=0, idle=1.
// - wr_ready is 1 when all hold: vdp_super=1, FIFO not full, no wr_addr_load this cycle, no flush this cycle.
//   wr_ready is a registered-free combinational output.
// - Byte accept:
//   - Lane = ptr[1:0]. Write wr_data into that lane of pack_word and set pack_be[lane].
//   - pack_waddr = ptr[19:2]; ptr = ptr+1, wrapping modulo 2^20.
// - Lane 3 accept: the completed word, including this byte, is pushed to the FIFO on the same edge. The pack then becomes empty.
// - wr_addr_load:
//   - If the pack is non-empty and wr_addr_in[19:2] != pack_waddr, push the partial word first, then load ptr.
//   - Otherwise load ptr only; the pack is kept so the word can keep merging.
//   - When wr_addr_load and wr_data_valid coincide, the load wins and the byte is not accepted.
// - flush: push the pack if it is non-empty. An empty pack is a no-op. No push when the FIFO is full: the flush is held pending until space frees.
// - Issuer FSM:
//   - IDLE -> REQ when the FIFO is non-empty, vdp_super=1 and super_res_drawing=0.
//   - On that edge, register the head into vram_addr/wdata/be and set vram_req=1.
//   - REQ: all outputs are held stable until vram_ack, even if super_res_drawing rises.
//   - On vram_ack: pop the head, vram_req=0, go to IDLE. The next request is raised no earlier than the following cycle.
//   - vram_ack while in IDLE is ignored.
// - vdp_super=0: wr_ready=0 and no new request is raised. An outstanding request completes normally. Contents and ptr are retained.
// - Push and pop in the same cycle: the count is unchanged. Full-depth queueing loses no data.
// - idle is combinational: pack_be==0 && FIFO empty && state==IDLE.
// CONFIGURATION
// - VDP_SUPER_RES_WR_AUTOFLUSH_EN defined:
//   - A counter tracks cycles with a non-empty pack and no accept.
//   - On reaching FLUSH_TIMEOUT the pack is pushed, exactly as for flush.
//   - An accept or address load resets the counter.
// - Macro undefined: no counter. A partial word leaves the pack only on lane-3 completion, a non-contiguous load, or flush.
// TESTING
// - Load 0x00000, write bytes 11,22,33,44, hold super_res_drawing=0
//   -> one request: vram_addr=0, wdata=0x44332211, be=F. ack -> idle=1.
// - Load 0x00005, write AA,BB, then flush
//   -> addr=1, wdata=0x00BBAA00, be=6.
// - Keep super_res_drawing=1, stream 20 bytes from address 0
//   -> wr_ready drops after 16 bytes (4 words queued), no vram_req.
//   -> Release the bus -> 4 requests at addr 0..3, one per ack, then wr_ready=1.
// - Raise super_res_drawing during REQ
//   -> vram_req and data stay stable until ack. No new request until drawing=0.
// - Load 0xFFFFF, write 01,02
//   -> first request addr=0x3FFFF be=8; second byte packs at addr 0 lane 0 (wrap).
// - Macro on, FLUSH_TIMEOUT=64: write one byte at 0x10 and wait
//   -> request at cycle 64: addr=4, be=1. Macro off -> no request.

Source files
------------

// File: rtl/vdp_super_res_writer.sv
// CPU-side byte packer and VRAM write issuer for the super-res/super-mid pixel path.
// Optional idle auto-flush of partial words: define VDP_SUPER_RES_WR_AUTOFLUSH_EN.
module vdp_super_res_writer #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned FLUSH_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vdp_super,
    input  logic        super_res_drawing,
    input  logic        wr_addr_load,
    input  logic [19:0] wr_addr_in,
    input  logic        wr_data_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic        flush,
    output logic        vram_req,
    output logic [17:0] vram_addr,
    output logic [31:0] vram_wdata,
    output logic [3:0]  vram_be,
    input  logic        vram_ack,
    output logic        idle
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FLUSH_TIMEOUT == 0) begin : g_param_check
        $error("vdp_super_res_writer: FIFO_DEPTH must be a power of 2 >= 2, FLUSH_TIMEOUT nonzero");
    end

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_t;

    state_t      state, state_d;
    logic        load_head;

    logic [19:0] ptr, ptr_d;
    logic [31:0] pack_word, pack_word_d;
    logic [3:0]  pack_be, pack_be_d;
    logic [17:0] pack_waddr, pack_waddr_d;
    logic        flush_pend, flush_pend_d;
    logic        ld_pend, ld_pend_d;
    logic [19:0] ld_addr, ld_addr_d;

    logic [17:0] fifo_addr [FIFO_DEPTH];
    logic [31:0] fifo_data [FIFO_DEPTH];
    logic [3:0]  fifo_be   [FIFO_DEPTH];
    logic [AW-1:0] wr_idx, rd_idx;
    logic [CW-1:0] count;
    logic        full, empty;

    logic        push, pop, accept, timeout_hit;
    logic [17:0] push_addr;
    logic [31:0] push_data;
    logic [3:0]  push_be;

    logic        pack_nonempty, flush_req, load_req;
    logic [19:0] load_addr;
    logic [1:0]  lane;
    logic [31:0] merged_word;
    logic [3:0]  merged_be;

    assign full          = (count == CW'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign pack_nonempty = (pack_be != 4'b0000);

    // A load or flush that could not push (FIFO full or writer frozen) is
    // parked in *_pend; byte accepts stay blocked until it has resolved.
    assign wr_ready = reset_n && vdp_super && !full && !wr_addr_load && !flush
                      && !flush_pend && !ld_pend;
    assign accept   = wr_data_valid && wr_ready;

`ifdef VDP_SUPER_RES_WR_AUTOFLUSH_EN
    localparam int unsigned TW = $clog2(FLUSH_TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;

    assign timeout_hit = vdp_super && pack_nonempty && !accept && (idle_cnt == TW'(FLUSH_TIMEOUT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            idle_cnt <= '0;
        else if (accept || wr_addr_load || !pack_nonempty || timeout_hit)
            idle_cnt <= '0;
        else if (vdp_super && idle_cnt != TW'(FLUSH_TIMEOUT))
            idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        lane        = ptr[1:0];
        merged_word = pack_word;
        merged_word[{lane, 3'b000} +: 8] = wr_data;
        merged_be   = pack_be | (4'b0001 << lane);
    end

    always_comb begin
        ptr_d        = ptr;
        pack_word_d  = pack_word;
        pack_be_d    = pack_be;
        pack_waddr_d = pack_waddr;
        flush_pend_d = flush_pend;
        ld_pend_d    = ld_pend;
        ld_addr_d    = ld_addr;
        push         = 1'b0;
        push_addr    = pack_waddr;
        push_data    = pack_word;
        push_be      = pack_be;
        flush_req    = flush || flush_pend || timeout_hit;
        load_req     = wr_addr_load || ld_pend;
        load_addr    = wr_addr_load ? wr_addr_in : ld_addr;

        if (!vdp_super) begin
            if (flush)
                flush_pend_d = 1'b1;
            if (wr_addr_load) begin
                ld_pend_d = 1'b1;
                ld_addr_d = wr_addr_in;
            end
        end else if (flush_req) begin
            // Flush resolves before a coincident or parked load; the outcome
            // matches load-then-flush because the load then sees an empty pack.
            if (!pack_nonempty || !full) begin
                if (pack_nonempty) begin
                    push        = 1'b1;
                    pack_be_d   = '0;
                    pack_word_d = '0;
                end
                flush_pend_d = 1'b0;
                if (load_req) begin
                    ptr_d     = load_addr;
                    ld_pend_d = 1'b0;
                end
            end else begin
                flush_pend_d = 1'b1;
                if (load_req) begin
                    ld_pend_d = 1'b1;
                    ld_addr_d = load_addr;
                end
            end
        end else if (load_req) begin
            if (pack_nonempty && load_addr[19:2] != pack_waddr) begin
                if (!full) begin
                    push        = 1'b1;
                    pack_be_d   = '0;
                    pack_word_d = '0;
                    ptr_d       = load_addr;
                    ld_pend_d   = 1'b0;
                end else begin
                    ld_pend_d = 1'b1;
                    ld_addr_d = load_addr;
                end
            end else begin
                ptr_d     = load_addr;
                ld_pend_d = 1'b0;
            end
        end else if (accept) begin
            ptr_d = ptr + 20'd1;
            if (lane == 2'd3) begin
                push        = 1'b1;
                push_addr   = ptr[19:2];
                push_data   = merged_word;
                push_be     = merged_be;
                pack_be_d   = '0;
                pack_word_d = '0;
            end else begin
                pack_word_d  = merged_word;
                pack_be_d    = merged_be;
                pack_waddr_d = ptr[19:2];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= '0;
            pack_word  <= '0;
            pack_be    <= '0;
            pack_waddr <= '0;
            flush_pend <= 1'b0;
            ld_pend    <= 1'b0;
            ld_addr    <= '0;
        end else begin
            ptr        <= ptr_d;
            pack_word  <= pack_word_d;
            pack_be    <= pack_be_d;
            pack_waddr <= pack_waddr_d;
            flush_pend <= flush_pend_d;
            ld_pend    <= ld_pend_d;
            ld_addr    <= ld_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_idx] <= push_addr;
            fifo_data[wr_idx] <= push_data;
            fifo_be[wr_idx]   <= push_be;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_idx <= wr_idx + 1'b1;
            if (pop)
                rd_idx <= rd_idx + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_d   = state;
        load_head = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && vdp_super && !super_res_drawing) begin
                    load_head = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (vram_ack) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            vram_req   <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            vram_be    <= '0;
        end else begin
            state    <= state_d;
            vram_req <= (state_d == ST_REQ);
            if (load_head) begin
                vram_addr  <= fifo_addr[rd_idx];
                vram_wdata <= fifo_data[rd_idx];
                vram_be    <= fifo_be[rd_idx];
            end
        end
    end

    assign idle = !pack_nonempty && empty && (state == ST_IDLE);

endmodule
